conv_kernel_sequencer: RTL and testbench
========================================

Name: conv_kernel_sequencer

Overview:
Controller that configures the 3x3 convolution datapath.
- Collects kernel coefficients and a normalising shift from the AXI4-Lite register block into a shadow bank.
- On commit, waits for an inter-frame gap and stalls the datapath.
- Streams the 10 configuration words into the datapath over a valid/ready handshake, so each frame is filtered by exactly one kernel.

Parameters:
- COEF_W, 16, signed coefficient width; also the k_data width.
- SHIFT_W, 4, width of the normalising right-shift field.
- CNT_W, 16, width of the load_count statistics counter.

Ports:
- ACLK  in  1  system clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- cfg_wr_en  in  1  single-cycle write strobe from the register block.
- cfg_addr  in  4  word index: 0-8 = coefficients c0..c8 (row-major), 9 = shift.
- cfg_wdata  in  COEF_W  write data; for addr 9 only the low SHIFT_W bits are used.
- cfg_commit  in  1  single-cycle request to apply the shadow bank.
- frame_sof  in  1  pulse on the accepted first pixel of a frame (tuser beat).
- frame_done  in  1  pulse when the datapath has emitted the last pixel of a frame.
- k_valid  out  1  coefficient word valid.
- k_ready  in  1  datapath accepts the coefficient word.
- k_index  out  4  index of the current word, 0..9.
- k_data  out  COEF_W  coefficient word; for index 9 it is the shift, zero-extended.
- hold  out  1  datapath must not start a new frame while high.
- busy  out  1  pending | (state != IDLE); readable as a status bit.
- cfg_err  out  1  one-cycle pulse when a write targets addr 10-15.
- load_count  out  CNT_W  number of completed loads; wraps modulo 2^CNT_W.

Behaviour:
Reset values (ARESETN=0, asynchronous):
- All outputs 0.
- Shadow and staging banks 0.
- pending=0, frame_active=0, state=IDLE.

Shadow writes:
- On cfg_wr_en with addr<=9, the shadow word is updated on the next edge. Writes are accepted in every state.
- addr>=10: write ignored; cfg_err=1 for exactly the following cycle.

pending:
- Set on cfg_commit.
- Cleared on the IDLE->LOAD transition.
- cfg_commit in the same cycle as that transition leaves pending=1 (set wins).

frame_active (registered):
- frame_sof -> 1, else frame_done -> 0, else hold.
- frame_sof has priority when both pulse in the same cycle.

State machine:
- IDLE: when pending & !frame_active & !frame_sof, copy shadow into staging, clear pending, go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - hold=1, k_valid=1; k_index/k_data come from staging[idx]. idx starts at 0.
  - On k_valid & k_ready, idx increments.
  - When idx==9 is accepted, go to DONE.
  - k_index and k_data stay stable while k_ready=0, for an unbounded stall.
- DONE: one cycle; hold=1, k_valid=0; load_count increments; then go to IDLE.
- hold deasserts on the first IDLE cycle after DONE.

Timing and boundary rules:
- Minimum latency, commit to first k_valid: 2 cycles. Commit at edge t sets pending; LOAD is entered at t+1; k_valid is visible from t+1 after the edge.
- Minimum load with k_ready tied high: 10 LOAD cycles plus 1 DONE cycle.
- Shadow writes during LOAD/DONE do not affect staging. A commit issued during LOAD queues a second load.
- frame_sof while hold=1 is a datapath protocol violation: it updates frame_active but does not disturb the load in progress.
- Reset mid-LOAD: all outputs drop to 0 immediately, no partial state survives, and no load_count increment occurs.

Test Plan:
- Reset, then write c0..c8 = 1..9 and shift=4, then commit with no frame active and k_ready=1 -> k_valid on 10 consecutive cycles, words 1,2,...,9,4 with index 0..9; hold high for 11 cycles; load_count=1; busy=0 afterwards.
- frame_sof, then commit, then frame_done 50 cycles later -> k_valid stays 0 and busy=1 throughout the frame; LOAD starts the cycle after frame_done is registered.
- k_ready toggling 1,0,0,1... during a load -> k_index/k_data held stable during every stall cycle; all 10 words delivered in order, none duplicated.
- Write c4=0x7FFF during LOAD, then commit during LOAD -> first load delivers the old c4; a second load follows immediately and delivers 0x7FFF; load_count increments by 2.
- Write to addr 12 -> cfg_err pulses for exactly 1 cycle; shadow unchanged, as confirmed by the next load's words.
- Deassert ARESETN at idx=5 of a load -> k_valid, hold and busy go to 0 asynchronously; load_count remains 0; after release, a fresh commit delivers zero words.

Source files
------------

// File: rtl/conv_kernel_sequencer.sv
// Loads a 3x3 kernel plus normalising shift from a shadow bank into the
// convolution datapath between frames, one word per valid/ready handshake.
module conv_kernel_sequencer #(
   parameter int COEF_W  = 16,
   parameter int SHIFT_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic              cfg_wr_en,
   input  logic [3:0]        cfg_addr,
   input  logic [COEF_W-1:0] cfg_wdata,
   input  logic              cfg_commit,
   input  logic              frame_sof,
   input  logic              frame_done,
   output logic              k_valid,
   input  logic              k_ready,
   output logic [3:0]        k_index,
   output logic [COEF_W-1:0] k_data,
   output logic              hold,
   output logic              busy,
   output logic              cfg_err,
   output logic [CNT_W-1:0]  load_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic               pending_q, pending_d;
   logic               frame_active_q, frame_active_d;
   logic               cfg_err_q, cfg_err_d;
   logic [CNT_W-1:0]   load_count_q, load_count_d;
   logic [COEF_W-1:0]  shadow_q [10];
   logic [COEF_W-1:0]  shadow_d [10];
   logic [COEF_W-1:0]  staging_q [10];
   logic [COEF_W-1:0]  staging_d [10];
   logic               go_load_s;

   // Shadow bank write port and out-of-range write detection
   always_comb begin
      shadow_d  = shadow_q;
      cfg_err_d = 1'b0;
      if (cfg_wr_en && (cfg_addr <= 4'd9)) begin
         if (cfg_addr == 4'd9) begin
            shadow_d[9] = {{(COEF_W-SHIFT_W){1'b0}}, cfg_wdata[SHIFT_W-1:0]};
         end else begin
            shadow_d[cfg_addr] = cfg_wdata;
         end
      end else if (cfg_wr_en) begin
         cfg_err_d = 1'b1;
      end else begin
         cfg_err_d = 1'b0;
      end
   end

   // Commit request and frame-in-flight tracking; set/sof take priority
   always_comb begin
      if (cfg_commit) begin
         pending_d = 1'b1;
      end else if (go_load_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
      if (frame_sof) begin
         frame_active_d = 1'b1;
      end else if (frame_done) begin
         frame_active_d = 1'b0;
      end else begin
         frame_active_d = frame_active_q;
      end
   end

   // Load sequencer next-state logic
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      staging_d    = staging_q;
      load_count_d = load_count_q;
      go_load_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A sof in this very cycle means a frame is starting; wait for it to end
            if (pending_q && !frame_active_q && !frame_sof) begin
               go_load_s = 1'b1;
               staging_d = shadow_q;
               idx_d     = 4'd0;
               state_d   = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (k_ready) begin
               if (idx_q == 4'd9) begin
                  idx_d   = 4'd0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         ST_DONE: begin
            load_count_d = load_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d      = ST_IDLE;
         end
         default: begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and bank registers
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q        <= ST_IDLE;
         idx_q          <= 4'd0;
         pending_q      <= 1'b0;
         frame_active_q <= 1'b0;
         cfg_err_q      <= 1'b0;
         load_count_q   <= '0;
         for (int i = 0; i < 10; i++) begin
            shadow_q[i]  <= '0;
            staging_q[i] <= '0;
         end
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         pending_q      <= pending_d;
         frame_active_q <= frame_active_d;
         cfg_err_q      <= cfg_err_d;
         load_count_q   <= load_count_d;
         shadow_q       <= shadow_d;
         staging_q      <= staging_d;
      end
   end

   // Outputs decode straight from registers; word bus reads zero outside LOAD
   always_comb begin
      k_valid    = (state_q == ST_LOAD);
      hold       = (state_q != ST_IDLE);
      busy       = pending_q | (state_q != ST_IDLE);
      cfg_err    = cfg_err_q;
      load_count = load_count_q;
      if (state_q == ST_LOAD) begin
         k_index = idx_q;
         k_data  = staging_q[idx_q];
      end else begin
         k_index = 4'd0;
         k_data  = '0;
      end
   end

endmodule

// File: tb/tb_conv_kernel_sequencer.sv
// Scoreboard bench: commits push the expected 10-word load, a monitor pops
// and compares every accepted word and checks stall stability.
module tb_conv_kernel_sequencer;
   localparam int COEF_W  = 16;
   localparam int SHIFT_W = 4;
   localparam int CNT_W   = 16;

   logic              ACLK = 1'b0;
   logic              ARESETN = 1'b0;
   logic              cfg_wr_en = 1'b0;
   logic [3:0]        cfg_addr = 4'd0;
   logic [COEF_W-1:0] cfg_wdata = '0;
   logic              cfg_commit = 1'b0;
   logic              frame_sof = 1'b0;
   logic              frame_done = 1'b0;
   logic              k_valid;
   logic              k_ready = 1'b0;
   logic [3:0]        k_index;
   logic [COEF_W-1:0] k_data;
   logic              hold;
   logic              busy;
   logic              cfg_err;
   logic [CNT_W-1:0]  load_count;

   int n_vec = 0;
   int n_err = 0;
   logic [COEF_W-1:0] model_shadow [10];
   logic [19:0]       exp_q [$];
   bit                rand_ready = 1'b0;
   int                exp_loads = 0;

   conv_kernel_sequencer #(.COEF_W(COEF_W), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_commit(cfg_commit), .frame_sof(frame_sof), .frame_done(frame_done),
      .k_valid(k_valid), .k_ready(k_ready), .k_index(k_index), .k_data(k_data),
      .hold(hold), .busy(busy), .cfg_err(cfg_err), .load_count(load_count)
   );

   always #5 ACLK = ~ACLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      cfg_wr_en = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      tick();
      cfg_wr_en = 1'b0;
      if (a <= 4'd9) model_shadow[a] = (a == 4'd9) ? {12'd0, d[3:0]} : d;
   endtask

   task automatic commit();
      for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), model_shadow[i]});
      exp_loads++;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         if (rand_ready) k_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_loads = 0;
      for (int i = 0; i < 10; i++) model_shadow[i] = '0;
   endtask

   task automatic do_reset();
      #2 ARESETN = 1'b0;
      model_reset();
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      tick();
   endtask

   // Monitor: compares each accepted word and holds the bus to stall stability
   initial begin
      logic        prev_stall;
      logic [3:0]  prev_idx;
      logic [15:0] prev_data;
      logic [19:0] e;
      prev_stall = 1'b0;
      prev_idx   = 4'd0;
      prev_data  = 16'd0;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_index", {28'd0, k_index}, {28'd0, prev_idx});
               check("stall_data", {16'd0, k_data}, {16'd0, prev_data});
            end
            if (k_valid && k_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_word: got idx %0d data %0h, expected no word", k_index, k_data);
               end else begin
                  e = exp_q.pop_front();
                  check("word_index", {28'd0, k_index}, {28'd0, e[19:16]});
                  check("word_data", {16'd0, k_data}, {16'd0, e[15:0]});
               end
            end
            prev_stall = k_valid && !k_ready;
            prev_idx   = k_index;
            prev_data  = k_data;
         end
      end
   end

   initial begin
      int first, nv, nh, p, n, base;
      model_reset();
      #23;
      check("rst_k_valid", {31'd0, k_valid}, 32'd0);
      check("rst_hold", {31'd0, hold}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
      check("rst_load_count", {16'd0, load_count}, 32'd0);
      check("rst_k_data", {12'd0, k_index, k_data}, 32'd0);
      @(negedge ACLK);
      ARESETN = 1'b1;
      tick();

      // Basic load: 1..9 and shift 4 (upper bits of the shift write discarded)
      for (int i = 0; i < 9; i++) wr(4'(i), 16'(i + 1));
      wr(4'd9, 16'hABC4);
      k_ready = 1'b1;
      commit();
      check("pre_load_k_valid", {31'd0, k_valid}, 32'd0);
      check("pre_load_busy", {31'd0, busy}, 32'd1);
      first = -1; nv = 0; nh = 0;
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (k_valid) begin
            nv++;
            if (first < 0) first = c;
         end
         if (hold) nh++;
      end
      check("first_valid_latency", 32'(first), 32'd1);
      check("valid_cycles", 32'(nv), 32'd10);
      check("hold_cycles", 32'(nh), 32'd11);
      check("load_count_1", {16'd0, load_count}, 32'd1);
      check("busy_after_1", {31'd0, busy}, 32'd0);

      // Commit inside a frame waits for frame_done
      frame_sof = 1'b1; tick(); frame_sof = 1'b0;
      commit();
      for (int c = 0; c < 50; c++) begin
         tick();
         check("frame_gap", {30'd0, k_valid, busy}, 32'd1);
      end
      frame_done = 1'b1; tick(); frame_done = 1'b0;
      check("gap_edge_k_valid", {31'd0, k_valid}, 32'd0);
      tick();
      check("load_after_done", {31'd0, k_valid}, 32'd1);
      wait_idle(50);
      check("load_count_2", {16'd0, load_count}, 32'd2);

      // Toggling ready 1,0,0,...
      commit();
      p = 0;
      while (busy && p < 200) begin
         k_ready = (p % 3 == 0);
         tick();
         p++;
      end
      check("toggle_timeout", {31'd0, busy}, 32'd0);
      check("load_count_3", {16'd0, load_count}, 32'd3);

      // Write and commit during LOAD: old c4 first, then a second load with 0x7FFF
      k_ready = 1'b0;
      commit();
      tick();
      check("stalled_in_load", {31'd0, k_valid}, 32'd1);
      wr(4'd4, 16'h7FFF);
      commit();
      rand_ready = 1'b1;
      wait_idle(300);
      rand_ready = 1'b0;
      check("load_count_5", {16'd0, load_count}, 32'd5);

      // Out-of-range write
      check("cfg_err_before", {31'd0, cfg_err}, 32'd0);
      wr(4'd12, 16'h1234);
      check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
      tick();
      check("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
      k_ready = 1'b1;
      commit();
      wait_idle(50);
      check("load_count_6", {16'd0, load_count}, 32'd6);

      // Randomised writes, frames and ready stalls
      base = 6;
      for (int it = 0; it < 30; it++) begin
         n = $urandom_range(0, 4);
         for (int w = 0; w < n; w++) wr(4'($urandom_range(0, 15)), 16'($urandom));
         if (it % 4 == 0) begin
            frame_sof = 1'b1; tick(); frame_sof = 1'b0;
            commit();
            n = $urandom_range(1, 20);
            for (int c = 0; c < n; c++) begin
               tick();
               check("rand_frame_gap", {31'd0, k_valid}, 32'd0);
            end
            frame_done = 1'b1; tick(); frame_done = 1'b0;
         end else begin
            commit();
         end
         rand_ready = 1'b1;
         wait_idle(300);
         rand_ready = 1'b0;
      end
      check("load_count_rand", {16'd0, load_count}, 32'(base + 30));

      // Reset in the middle of a load
      do_reset();
      check("count_after_reset", {16'd0, load_count}, 32'd0);
      for (int i = 0; i < 10; i++) wr(4'(i), 16'(16'h100 + i));
      k_ready = 1'b1;
      commit();
      n = 0;
      while (!(k_valid && k_index == 4'd5) && n < 30) begin
         tick();
         n++;
      end
      check("reach_idx5", {31'd0, k_valid}, 32'd1);
      ARESETN = 1'b0;
      #1;
      check("async_k_valid", {31'd0, k_valid}, 32'd0);
      check("async_hold", {31'd0, hold}, 32'd0);
      check("async_busy", {31'd0, busy}, 32'd0);
      check("async_load_count", {16'd0, load_count}, 32'd0);
      model_reset();
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      tick();
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      check("post_reset_count", {16'd0, load_count}, 32'd0);
      commit();
      wait_idle(50);
      check("post_reset_load_count", {16'd0, load_count}, 32'd1);

      tick();
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete, expected completion");
      $fatal(1);
   end
endmodule
